timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
Main counter stage of the general-purpose timer. It sits directly downstream of the prescaler and consumes the prescaler tick as its count enable.
- Counts up, down or center-aligned against an auto-reload value (ARR).
- Produces the update event (UEV), which feeds the prescaler's uev_i so both shadow registers reload on the same edge.
- Raises a sticky update interrupt flag and supports one-pulse mode.

Parameters:
CNT_WIDTH, 16, width of counter and ARR.

Ports:
clk_i  input  1  timer clock (same clock as the prescaler).
rst_i  input  1  reset; synchronous, active-high.
cen_i  input  1  counter enable (CR1.CEN).
tick_i  input  1  prescaler tick (prescaler clk_o); one-cycle pulse.
arr_i  input  CNT_WIDTH  auto-reload value from the register file.
arpe_i  input  1  ARR preload enable.
dir_i  input  1  direction in edge mode; 0 = up, 1 = down.
cms_i  input  2  mode; 00 = edge-aligned, any other value = center-aligned.
opm_i  input  1  one-pulse mode.
udis_i  input  1  suppress UEV caused by overflow/underflow.
ug_i  input  1  software update generation; one-cycle pulse.
uif_clr_i  input  1  clear the update interrupt flag.
cnt_o  output  CNT_WIDTH  current counter value.
dir_o  output  1  actual counting direction.
uev_o  output  1  update event pulse; drives prescaler uev_i.
uif_o  output  1  sticky update interrupt flag.
cen_clr_o  output  1  one-cycle request to clear CEN (OPM stop).

Behaviour:
- Reset (rst_i high at a clk_i edge): cnt_o = 0, arr_shadow = 0, dir_o = 0, uif_o = 0. uev_o and cen_clr_o read 0 while rst_i is high. Reset overrides every other input.
- Effective reload: arr_eff = arpe_i ? arr_shadow : arr_i. arr_shadow <= arr_i on every clock edge where uev_o = 1.
- Step condition: step = cen_i & tick_i. With no step and no ug_i, all state holds.
- arr_eff == 0: counter held at 0, no wrap events (blocked counter). ug_i still works.
- Edge-aligned up (cms_i = 00, dir_i = 0):
  - on step, if cnt_o >= arr_eff then cnt_o <= 0 and wrap = 1;
  - otherwise cnt_o <= cnt_o + 1.
  - Using >= means an ARR lowered below the current count wraps on the next step.
- Edge-aligned down (dir_i = 1): on step, if cnt_o == 0 then cnt_o <= arr_eff and wrap = 1; otherwise cnt_o <= cnt_o - 1.
- dir_o equals dir_i in edge mode. A dir_i change takes effect at the next step.
- Center-aligned (cms_i != 00): dir_i is ignored; dir_o is internal state.
  - Up phase, step with cnt_o >= arr_eff: cnt_o <= arr_eff - 1, dir_o <= 1, wrap = 1 (overflow).
  - Down phase, step with cnt_o == 0: cnt_o <= 1, dir_o <= 0, wrap = 1 (underflow).
  - Other steps count by 1 in the dir_o direction.
- Entering center mode from edge mode: dir_o <= 0 at the first step.
- uev_o = ug_i | (wrap & ~udis_i). It is combinational from state and inputs, asserted in the same cycle as the wrapping step. All shadows (local and prescaler) update on that edge.
- ug_i reinitialises and has priority over a same-cycle step:
  - cnt_o <= 0 in up or center mode, cnt_o <= arr_i in down mode;
  - center mode: dir_o <= 0;
  - the reload value is the newly loaded arr_i.
- uif_o: set on any uev_o. Cleared by uif_clr_i. Set wins over a simultaneous clear.
- One-pulse mode (opm_i = 1): on a wrap,
  - cen_clr_o pulses in the same cycle, whether or not udis_i suppresses the UEV;
  - the counter takes its wrapped value and then holds, because the register file drops CEN.
- ug_i never asserts cen_clr_o.
- Arithmetic is CNT_WIDTH unsigned; there is no implicit overflow past all-ones, because wrap occurs at arr_eff.
- Reset mid-count: the next cycle behaves exactly as after power-up.

Decomposition:
- Shared package gpt_pkg holds:
  - cms_e typedef (CMS_EDGE = 2'b00, CMS_CENTER1/2/3);
  - DIR_UP/DIR_DOWN constants;
  - default CNT_WIDTH/PSC_WIDTH.
- No sub-module: a single always_ff for cnt/dir/arr_shadow/uif plus combinational next-state and wrap logic.
- The timer top instantiates prescaler, then timer_counter, with uev_o looped back to the prescaler uev_i.

Test Plan:
- Up mode, arr_i = 4, arpe_i = 0, tick_i every cycle, cen_i = 1 -> cnt_o 0,1,2,3,4,0. uev_o high in the cycle cnt_o == 4. uif_o = 1 the next cycle.
- Down mode, arr_i = 3, tick every 3rd cycle -> cnt_o 3,2,1,0,3 changing only on ticks. uev_o pulses with the 0->3 step.
- Center mode, arr_i = 3 -> cnt_o 0,1,2,3,2,1,0,1. Two uev_o pulses per period, at 3->2 and 0->1. dir_o toggles at each.
- arpe_i = 1, arr_i changed 5->2 mid-count -> current period still wraps at 5; next period wraps at 2. With arpe_i = 0 and cnt_o = 4, the next step wraps to 0.
- opm_i = 1, up, arr_i = 2 -> cen_clr_o and uev_o pulse together at the 2->0 step. With udis_i = 1 -> cen_clr_o still pulses, uev_o does not, and uif_o stays 0.
- ug_i in the same cycle as a wrap step with uif_clr_i = 1, down mode, arr_i = 7 -> cnt_o = 7, uev_o = 1, uif_o = 1. rst_i mid-count -> all outputs 0 next cycle.

Source files
------------

// File: rtl/gpt_pkg.sv
// Shared types and defaults for the general-purpose timer slice
// (prescaler + main counter).
package gpt_pkg;

  typedef enum logic [1:0] {
    CMS_EDGE    = 2'b00,
    CMS_CENTER1 = 2'b01,
    CMS_CENTER2 = 2'b10,
    CMS_CENTER3 = 2'b11
  } cms_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int CNT_WIDTH_DEF = 16;
  localparam int PSC_WIDTH_DEF = 16;

endpackage

// File: rtl/timer_counter_if.sv
// Register-file / prescaler side of the main counter stage.
// Every signal is level-sampled at clk_i; tick_i, ug_i and the uev_o/cen_clr_o outputs are one-cycle pulses (no handshake).
interface timer_counter_if #(
  parameter int CNT_WIDTH = gpt_pkg::CNT_WIDTH_DEF
);
  logic                 cen_i;
  logic                 tick_i;
  logic [CNT_WIDTH-1:0] arr_i;
  logic                 arpe_i;
  logic                 dir_i;
  logic [1:0]           cms_i;
  logic                 opm_i;
  logic                 udis_i;
  logic                 ug_i;
  logic                 uif_clr_i;
  logic [CNT_WIDTH-1:0] cnt_o;
  logic                 dir_o;
  logic                 uev_o;
  logic                 uif_o;
  logic                 cen_clr_o;

  modport master (
    output cen_i, tick_i, arr_i, arpe_i, dir_i, cms_i, opm_i, udis_i, ug_i, uif_clr_i,
    input  cnt_o, dir_o, uev_o, uif_o, cen_clr_o
  );

  modport slave (
    input  cen_i, tick_i, arr_i, arpe_i, dir_i, cms_i, opm_i, udis_i, ug_i, uif_clr_i,
    output cnt_o, dir_o, uev_o, uif_o, cen_clr_o
  );
endinterface

// File: rtl/timer_counter.sv
// Main counter stage of the timer: up/down/center-aligned counting against ARR,
// update event generation, sticky update flag and one-pulse stop request.
module timer_counter
  import gpt_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  timer_counter_if.slave     bus
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t ONE = cnt_t'(1);

  cnt_t cnt_q, cnt_d, arr_shadow_q, arr_eff;
  logic dir_q, dir_d, dir_eff;
  logic center_q, center, step, wrap, uif_q, uev;
  cms_e cms;

  assign cms     = cms_e'(bus.cms_i);
  assign center  = (cms != CMS_EDGE);
  assign step    = bus.cen_i & bus.tick_i;
  assign arr_eff = bus.arpe_i ? arr_shadow_q : bus.arr_i;

  // A step in center mode right after edge mode restarts in the up phase.
  assign dir_eff = center ? (center_q ? dir_q : DIR_UP) : bus.dir_i;

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    wrap  = 1'b0;
    if (bus.ug_i) begin
      cnt_d = (!center && bus.dir_i == DIR_DOWN) ? bus.arr_i : '0;
      dir_d = center ? DIR_UP : bus.dir_i;
    end else if (step) begin
      dir_d = dir_eff;
      if (arr_eff == '0) begin
        cnt_d = '0;
      end else if (dir_eff == DIR_UP) begin
        if (cnt_q >= arr_eff) begin
          wrap = 1'b1;
          if (center) begin
            cnt_d = arr_eff - ONE;
            dir_d = DIR_DOWN;
          end else begin
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          wrap = 1'b1;
          if (center) begin
            cnt_d = ONE;
            dir_d = DIR_UP;
          end else begin
            cnt_d = arr_eff;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  assign uev           = ~rst_i & (bus.ug_i | (wrap & ~bus.udis_i));
  assign bus.uev_o     = uev;
  assign bus.cen_clr_o = ~rst_i & bus.opm_i & wrap;
  assign bus.cnt_o     = cnt_q;
  assign bus.dir_o     = dir_q;
  assign bus.uif_o     = uif_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      center_q     <= 1'b0;
      arr_shadow_q <= '0;
      uif_q        <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      if (bus.ug_i || step) center_q <= center;
      if (uev) arr_shadow_q <= bus.arr_i;
      if (uev) uif_q <= 1'b1;
      else if (bus.uif_clr_i) uif_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed and randomized bench for timer_counter against a behavioural model.
module tb_timer_counter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  timer_counter_if #(.CNT_WIDTH(W)) bus ();
  timer_counter #(.CNT_WIDTH(W)) dut (.clk_i(clk), .rst_i(rst_i), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // model state and one-cycle prediction
  int m_cnt, m_shadow;
  bit m_dir, m_uif, m_center_prev;
  int p_cnt, p_shadow;
  bit p_dir, p_uif, p_center_prev, p_uev, p_cclr;
  logic obs_uev, obs_cclr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic predict();
    int  arr;
    bit  center, wrap, d;
    arr    = bus.arpe_i ? m_shadow : int'(bus.arr_i);
    center = (bus.cms_i != 2'b00);
    wrap   = 0;
    p_cnt = m_cnt; p_dir = m_dir; p_center_prev = m_center_prev;
    if (bus.ug_i) begin
      p_cnt = (center || !bus.dir_i) ? 0 : int'(bus.arr_i);
      p_dir = center ? 1'b0 : bus.dir_i;
      p_center_prev = center;
    end else if (bus.cen_i && bus.tick_i) begin
      p_center_prev = center;
      d = center ? (m_center_prev ? m_dir : 1'b0) : bus.dir_i;
      p_dir = d;
      if (arr == 0) p_cnt = 0;
      else if (!d) begin
        if (m_cnt >= arr) begin
          wrap = 1;
          p_cnt = center ? arr - 1 : 0;
          if (center) p_dir = 1;
        end else p_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin
          wrap = 1;
          p_cnt = center ? 1 : arr;
          if (center) p_dir = 0;
        end else p_cnt = m_cnt - 1;
      end
    end
    p_uev  = bus.ug_i | (wrap & ~bus.udis_i);
    p_cclr = bus.opm_i & wrap;
    p_uif  = p_uev ? 1'b1 : (bus.uif_clr_i ? 1'b0 : m_uif);
    p_shadow = p_uev ? int'(bus.arr_i) : m_shadow;
    if (rst_i) begin
      p_cnt = 0; p_dir = 0; p_uif = 0; p_shadow = 0; p_center_prev = 0;
      p_uev = 0; p_cclr = 0;
    end
  endtask

  // One clock: pulses checked mid-cycle, registered state checked #1 after the edge.
  task automatic cyc();
    @(negedge clk);
    obs_uev  = bus.uev_o;
    obs_cclr = bus.cen_clr_o;
    predict();
    chk("uev_o", obs_uev, p_uev);
    chk("cen_clr_o", obs_cclr, p_cclr);
    @(posedge clk);
    #1;
    m_cnt = p_cnt; m_dir = p_dir; m_uif = p_uif; m_shadow = p_shadow; m_center_prev = p_center_prev;
    chk("cnt_o", bus.cnt_o, m_cnt);
    chk("dir_o", bus.dir_o, m_dir);
    chk("uif_o", bus.uif_o, m_uif);
  endtask

  task automatic idle_inputs();
    bus.cen_i = 1; bus.tick_i = 1; bus.arr_i = '0; bus.arpe_i = 0; bus.dir_i = 0;
    bus.cms_i = 2'b00; bus.opm_i = 0; bus.udis_i = 0; bus.ug_i = 0; bus.uif_clr_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1;
    cyc();
    rst_i = 0;
  endtask

  initial begin
    int exp_up[5]     = '{1, 2, 3, 4, 0};
    int exp_dn[5]     = '{3, 2, 1, 0, 3};
    int exp_ctr[7]    = '{1, 2, 3, 2, 1, 0, 1};
    int exp_arpe[9]   = '{1, 2, 3, 4, 5, 0, 1, 2, 0};
    int k;
    m_cnt = 0; m_shadow = 0; m_dir = 0; m_uif = 0; m_center_prev = 0;
    idle_inputs();
    bus.ug_i = 1;
    rst_i = 1;
    cyc();
    chk("rst_uev_gated", obs_uev, 1'b0);
    chk("rst_cnt", bus.cnt_o, 0);
    chk("rst_uif", bus.uif_o, 0);
    idle_inputs();
    rst_i = 0;

    // edge-aligned up, ARR = 4
    bus.arr_i = 4;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("up_seq", bus.cnt_o, exp_up[i]);
      if (i == 4) chk("up_uev_at_4", obs_uev, 1'b1);
    end
    chk("up_uif", bus.uif_o, 1'b1);

    // edge-aligned down, ARR = 3, tick every third cycle
    do_reset();
    bus.dir_i = 1; bus.arr_i = 3; bus.tick_i = 0;
    k = 0;
    for (int i = 0; i < 15; i++) begin
      bus.tick_i = (i % 3 == 2);
      cyc();
      if (i % 3 == 2) begin
        chk("dn_seq", bus.cnt_o, exp_dn[k]);
        if (k == 0 || k == 4) chk("dn_uev", obs_uev, 1'b1);
        k++;
      end
    end
    bus.tick_i = 1; bus.dir_i = 0;

    // center-aligned, ARR = 3
    do_reset();
    bus.cms_i = 2'b01; bus.arr_i = 3; bus.dir_i = 1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("ctr_seq", bus.cnt_o, exp_ctr[i]);
      if (i == 3 || i == 6) chk("ctr_uev", obs_uev, 1'b1);
    end
    bus.cms_i = 2'b00; bus.dir_i = 0;

    // ARR preload: change 5->2 mid-count; wrap at 5, then at 2
    do_reset();
    bus.arpe_i = 1; bus.arr_i = 5; bus.ug_i = 1; bus.tick_i = 0;
    cyc();
    bus.ug_i = 0; bus.tick_i = 1;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) bus.arr_i = 2;
      cyc();
      chk("arpe_seq", bus.cnt_o, exp_arpe[i]);
    end
    // no preload: ARR lowered below count wraps on next step
    bus.arpe_i = 0; bus.arr_i = 5;
    for (int i = 0; i < 4; i++) cyc();
    chk("noarpe_at4", bus.cnt_o, 4);
    bus.arr_i = 2;
    cyc();
    chk("noarpe_wrap", bus.cnt_o, 0);

    // one-pulse mode, with and without UDIS
    for (int u = 0; u < 2; u++) begin
      do_reset();
      bus.opm_i = 1; bus.arr_i = 2; bus.udis_i = (u == 1);
      cyc(); cyc(); cyc();
      chk("opm_cclr", obs_cclr, 1'b1);
      chk("opm_uev", obs_uev, (u == 0));
      chk("opm_uif", bus.uif_o, (u == 0));
      chk("opm_cnt", bus.cnt_o, 0);
      bus.cen_i = 0;
      cyc(); cyc();
      chk("opm_hold", bus.cnt_o, 0);
      bus.cen_i = 1; bus.opm_i = 0; bus.udis_i = 0;
    end

    // UG against a same-cycle wrap step, with a flag clear
    do_reset();
    bus.dir_i = 1; bus.arr_i = 7; bus.ug_i = 1; bus.uif_clr_i = 1;
    cyc();
    chk("ug_cnt", bus.cnt_o, 7);
    chk("ug_uev", obs_uev, 1'b1);
    chk("ug_cclr", obs_cclr, 1'b0);
    chk("ug_uif", bus.uif_o, 1'b1);
    bus.ug_i = 0; bus.uif_clr_i = 0;
    cyc(); cyc();
    rst_i = 1;
    cyc();
    rst_i = 0;
    chk("midrst_cnt", bus.cnt_o, 0);
    chk("midrst_dir", bus.dir_i ? bus.dir_o : 1'b0, 0);

    // randomized stimulus against the model
    idle_inputs();
    for (int i = 0; i < 600; i++) begin
      rst_i         = ($urandom_range(0, 59) == 0);
      bus.cen_i     = ($urandom_range(0, 9) != 0);
      bus.tick_i    = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) bus.arr_i = W'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) bus.arpe_i = ~bus.arpe_i;
      if ($urandom_range(0, 19) == 0) bus.dir_i = ~bus.dir_i;
      if ($urandom_range(0, 39) == 0) bus.cms_i = 2'($urandom_range(0, 3));
      bus.opm_i     = ($urandom_range(0, 5) == 0);
      bus.udis_i    = ($urandom_range(0, 4) == 0);
      bus.ug_i      = ($urandom_range(0, 24) == 0);
      bus.uif_clr_i = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
